// File: rtl/cordic_arbiter.sv
// cordic_arbiter: shares one CORDIC core among NREQ requesters, round-robin, with a watchdog.
// Optional CORDIC_ARB_STATS_EN adds saturating ops_count/err_count outputs.
module cordic_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 16,
  parameter int TIMEOUT = 63,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   gnt,
  output logic              core_start,
  output logic [W-1:0]      core_x,
  output logic [W-1:0]      core_y,
  output logic [W-1:0]      core_a,
  output logic [W-1:0]      core_b,
  input  logic              core_done,
  input  logic [W-1:0]      core_X,
  input  logic [W-1:0]      core_Y,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_X,
  output logic [W-1:0]      rsp_Y,
  output logic              rsp_err,
  output logic              busy
`ifdef CORDIC_ARB_STATS_EN
  ,
  output logic [15:0]       ops_count,
  output logic [7:0]        err_count
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_q, rr_d, id_q, id_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [W-1:0]    opx_q, opx_d, opy_q, opy_d, opa_q, opa_d, opb_q, opb_d;
  logic [W-1:0]    rx_q, rx_d, ry_q, ry_d;
  logic            err_q, err_d, start_q, start_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            found;
  logic [IDW-1:0]  pick;

`ifdef CORDIC_ARB_STATS_EN
  logic [15:0] ops_q, ops_d;
  logic [7:0]  errc_q, errc_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
`endif

  // Round-robin scan starting at rr_q, wrapping modulo NREQ
  always_comb begin : scan
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    opx_d   = opx_q;
    opy_d   = opy_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    err_d   = err_q;
    gnt_d   = '0;
    start_d = 1'b0;
`ifdef CORDIC_ARB_STATS_EN
    ops_d   = ops_q;
    errc_d  = errc_q;
`endif
    case (state_q)
      IDLE: if (found) begin
        state_d = ISSUE;
        id_d    = pick;
        opx_d   = req_x[int'(pick)*W +: W];
        opy_d   = req_y[int'(pick)*W +: W];
        opa_d   = req_a[int'(pick)*W +: W];
        opb_d   = req_b[int'(pick)*W +: W];
        gnt_d   = NREQ'(1) << pick;
        start_d = 1'b1;
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // cnt_d counts WAIT cycles including this one; a done in the last cycle still wins
        cnt_d = cnt_q + 8'd1;
        if (core_done) begin
          rx_d    = core_X;
          ry_d    = core_Y;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_d == TO_CNT) begin
          rx_d    = '0;
          ry_d    = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: if (rsp_ready) begin
        state_d = IDLE;
        rr_d    = (id_q == IDW'(NREQ-1)) ? '0 : id_q + IDW'(1);
`ifdef CORDIC_ARB_STATS_EN
        if (err_q) errc_d = sat_inc8(errc_q);
        else       ops_d  = sat_inc16(ops_q);
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      opx_q   <= '0;
      opy_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
      err_q   <= 1'b0;
      gnt_q   <= '0;
      start_q <= 1'b0;
`ifdef CORDIC_ARB_STATS_EN
      ops_q   <= '0;
      errc_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      opx_q   <= opx_d;
      opy_q   <= opy_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      err_q   <= err_d;
      gnt_q   <= gnt_d;
      start_q <= start_d;
`ifdef CORDIC_ARB_STATS_EN
      ops_q   <= ops_d;
      errc_q  <= errc_d;
`endif
    end
  end

  assign gnt        = gnt_q;
  assign core_start = start_q;
  assign core_x     = opx_q;
  assign core_y     = opy_q;
  assign core_a     = opa_q;
  assign core_b     = opb_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = id_q;
  assign rsp_X      = rx_q;
  assign rsp_Y      = ry_q;
  assign rsp_err    = err_q;
  assign busy       = (state_q != IDLE);
`ifdef CORDIC_ARB_STATS_EN
  assign ops_count  = ops_q;
  assign err_count  = errc_q;
`endif

endmodule

// File: tb/tb_cordic_arbiter.sv
// Self-checking bench for cordic_arbiter: randomized jobs against a cycle-count/round-robin model.
module tb_cordic_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int TO   = 63;

  logic        Clk, Reset;
  logic [3:0]  req;
  logic [63:0] req_x, req_y, req_a, req_b;
  logic [3:0]  gnt;
  logic        core_start, core_done, rsp_valid, rsp_ready, rsp_err, busy;
  logic [15:0] core_x, core_y, core_a, core_b, core_X, core_Y, rsp_X, rsp_Y;
  logic [1:0]  rsp_id;
`ifdef CORDIC_ARB_STATS_EN
  logic [15:0] ops_count;
  logic [7:0]  err_count;
`endif

  logic [15:0] ox[4], oy[4], oa[4], ob[4];
  int n_chk, n_fail, m_rr;

  cordic_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset(Reset), .req(req),
    .req_x(req_x), .req_y(req_y), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .core_start(core_start),
    .core_x(core_x), .core_y(core_y), .core_a(core_a), .core_b(core_b),
    .core_done(core_done), .core_X(core_X), .core_Y(core_Y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_X(rsp_X), .rsp_Y(rsp_Y), .rsp_err(rsp_err), .busy(busy)
`ifdef CORDIC_ARB_STATS_EN
    , .ops_count(ops_count), .err_count(err_count)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load_ops();
    for (int i = 0; i < 4; i++) begin
      ox[i] = 16'($urandom); oy[i] = 16'($urandom);
      oa[i] = 16'($urandom); ob[i] = 16'($urandom);
      req_x[i*16 +: 16] = ox[i]; req_y[i*16 +: 16] = oy[i];
      req_a[i*16 +: 16] = oa[i]; req_b[i*16 +: 16] = ob[i];
    end
  endtask

  function automatic int ref_pick(input logic [3:0] r, input int rr);
    for (int k = 0; k < 4; k++)
      if (r[(rr + k) % 4]) return (rr + k) % 4;
    return -1;
  endfunction

  // cycles after the issue cycle at which rsp_valid should first appear
  function automatic int exp_first(input int d);
    return (d <= TO) ? d + 1 : TO + 1;
  endfunction

  task automatic wait_start(output int cyc);
    cyc = 0;
    do begin tick(); cyc++; end while (!core_start && cyc < 20);
    if (!core_start) cyc = -1;
  endtask

  // Plays the core: done pulse d cycles after start; returns cycle of first rsp_valid (-1 if none)
  task automatic run_core(input int d, input logic [15:0] X, input logic [15:0] Y, output int first);
    first = -1;
    core_X = X;
    core_Y = Y;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (rsp_valid) begin first = k; break; end
      core_done = (k == d);
    end
    core_done = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    #22;
    n_chk++;
    if ({gnt, core_start, rsp_valid, busy, rsp_err} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0", {gnt, core_start, rsp_valid, busy, rsp_err});
    end
    n_chk++;
    if ({core_x, core_y, core_a, core_b, rsp_X, rsp_Y, rsp_id} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 0", {core_x, core_y, core_a, core_b, rsp_X, rsp_Y, rsp_id});
    end
    @(posedge Clk); #1;
    Reset = 1'b1;
    m_rr = 0;
  endtask

  task automatic test_single();
    int c, first;
    load_ops();
    ox[1] = 16'h1234;
    req_x[16 +: 16] = 16'h1234;
    req = 4'b0010;
    wait_start(c);
    n_chk++;
    if (c !== 1 || gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL single_gnt: got gnt=%b after %0d cycles expected 0010 after 1", gnt, c);
    end
    n_chk++;
    if ({core_x, core_y, core_a, core_b} !== {16'h1234, oy[1], oa[1], ob[1]}) begin
      n_fail++;
      $display("FAIL single_ops: got %h expected %h", {core_x, core_y, core_a, core_b}, {16'h1234, oy[1], oa[1], ob[1]});
    end
    req = 4'b0000;
    run_core(10, 16'h00AA, 16'h0055, first);
    n_chk++;
    if (first !== exp_first(10)) begin
      n_fail++;
      $display("FAIL single_latency: got %0d expected %0d", first, exp_first(10));
    end
    n_chk++;
    if ({rsp_id, rsp_X, rsp_Y, rsp_err, gnt, core_x} !== {2'd1, 16'h00AA, 16'h0055, 1'b0, 4'b0000, 16'h1234}) begin
      n_fail++;
      $display("FAIL single_rsp: got id=%0d X=%h Y=%h err=%b gnt=%b core_x=%h expected 1 00aa 0055 0 0000 1234",
               rsp_id, rsp_X, rsp_Y, rsp_err, gnt, core_x);
    end
    tick();
    n_chk++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_accept: got valid=%b busy=%b expected 0 0", rsp_valid, busy);
    end
    m_rr = 2;
  endtask

  task automatic test_round_robin();
    int c, first, w, d;
    logic [15:0] X, Y;
    for (int j = 0; j < 12; j++) begin
      load_ops();
      req = (j < 5) ? 4'b1111 : 4'($urandom_range(1, 15));
      w = ref_pick(req, m_rr);
      wait_start(c);
      n_chk++;
      if (c !== 1 || gnt !== (4'b0001 << w)) begin
        n_fail++;
        $display("FAIL rr_gnt[%0d]: got gnt=%b after %0d cycles expected %b after 1", j, gnt, c, 4'b0001 << w);
      end
      n_chk++;
      if ({core_x, core_y, core_a, core_b} !== {ox[w], oy[w], oa[w], ob[w]}) begin
        n_fail++;
        $display("FAIL rr_ops[%0d]: got %h expected %h", j, {core_x, core_y, core_a, core_b}, {ox[w], oy[w], oa[w], ob[w]});
      end
      d = $urandom_range(1, 8);
      X = 16'($urandom);
      Y = 16'($urandom);
      run_core(d, X, Y, first);
      n_chk++;
      if (first !== exp_first(d) || {rsp_id, rsp_X, rsp_Y, rsp_err} !== {2'(w), X, Y, 1'b0}) begin
        n_fail++;
        $display("FAIL rr_rsp[%0d]: got at %0d id=%0d X=%h Y=%h err=%b expected at %0d id=%0d X=%h Y=%h err=0",
                 j, first, rsp_id, rsp_X, rsp_Y, rsp_err, exp_first(d), w, X, Y);
      end
      tick();
      m_rr = (w + 1) % 4;
    end
    req = 4'b0000;
  endtask

  task automatic test_backpressure();
    int c, first, w, w2;
    logic [34:0] snap;
    logic [15:0] X, Y;
    load_ops();
    rsp_ready = 1'b0;
    req = 4'($urandom_range(1, 15));
    w = ref_pick(req, m_rr);
    wait_start(c);
    X = 16'($urandom);
    Y = 16'($urandom);
    run_core(3, X, Y, first);
    snap = {2'(w), X, Y, 1'b0};
    n_chk++;
    if (first !== exp_first(3) || {rsp_id, rsp_X, rsp_Y, rsp_err} !== snap) begin
      n_fail++;
      $display("FAIL bp_rsp: got at %0d %h expected at %0d %h", first, {rsp_id, rsp_X, rsp_Y, rsp_err}, exp_first(3), snap);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_chk++;
      if ({rsp_valid, gnt, busy, rsp_id, rsp_X, rsp_Y, rsp_err} !== {1'b1, 4'b0000, 1'b1, snap}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got valid=%b gnt=%b data=%h expected 1 0000 %h",
                 k, rsp_valid, gnt, {rsp_id, rsp_X, rsp_Y, rsp_err}, snap);
      end
    end
    rsp_ready = 1'b1;
    m_rr = (w + 1) % 4;
    w2 = ref_pick(req, m_rr);
    tick();
    n_chk++;
    if (rsp_valid !== 1'b0 || gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL bp_idle: got valid=%b gnt=%b expected 0 0000", rsp_valid, gnt);
    end
    tick();
    n_chk++;
    if (gnt !== (4'b0001 << w2) || core_start !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_next_gnt: got gnt=%b start=%b expected %b 1", gnt, core_start, 4'b0001 << w2);
    end
    req = 4'b0000;
    run_core(2, 16'h0, 16'h0, first);
    tick();
    m_rr = (w2 + 1) % 4;
  endtask

  task automatic test_timeout();
    int c, first, w, d;
    logic e;
    logic [15:0] X, Y;
    int dl[4] = '{1000, 63, 64, 62};
    for (int j = 0; j < 4; j++) begin
      d = dl[j];
      load_ops();
      req = 4'($urandom_range(1, 15));
      w = ref_pick(req, m_rr);
      wait_start(c);
      req = 4'b0000;
      X = 16'($urandom) | 16'h0001;
      Y = 16'($urandom) | 16'h0100;
      run_core(d, X, Y, first);
      e = (d > TO);
      n_chk++;
      if (first !== exp_first(d)) begin
        n_fail++;
        $display("FAIL to_latency[d=%0d]: got %0d expected %0d", d, first, exp_first(d));
      end
      n_chk++;
      if ({rsp_id, rsp_X, rsp_Y, rsp_err} !== {2'(w), e ? 16'h0 : X, e ? 16'h0 : Y, e}) begin
        n_fail++;
        $display("FAIL to_rsp[d=%0d]: got id=%0d X=%h Y=%h err=%b expected id=%0d err=%b", d, rsp_id, rsp_X, rsp_Y, rsp_err, w, e);
      end
      tick();
      m_rr = (w + 1) % 4;
    end
  endtask

  task automatic test_async_reset();
    int c, first;
    bit bad;
    load_ops();
    req = 4'b0100;
    wait_start(c);
    req = 4'b0000;
    run_core(2, 16'h1, 16'h2, first);
    tick();
    m_rr = 3;
    req = 4'b0001;
    wait_start(c);
    req = 4'b0000;
    repeat (4) tick();
    #3;
    Reset = 1'b0;
    #1;
    n_chk++;
    if ({gnt, core_start, rsp_valid, busy, rsp_err, core_x, core_y, core_a, core_b} !== '0) begin
      n_fail++;
      $display("FAIL areset_now: got busy=%b start=%b core_x=%h expected all 0", busy, core_start, core_x);
    end
    @(posedge Clk); #1;
    Reset = 1'b1;
    m_rr = 0;
    bad = 1'b0;
    core_done = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (rsp_valid || busy) bad = 1'b1;
    end
    core_done = 1'b0;
    n_chk++;
    if (bad) begin
      n_fail++;
      $display("FAIL areset_no_rsp: got a response or busy after reset, expected none");
    end
    req = 4'b1010;
    wait_start(c);
    n_chk++;
    if (gnt !== (4'b0001 << ref_pick(4'b1010, m_rr))) begin
      n_fail++;
      $display("FAIL areset_rr: got gnt=%b expected %b", gnt, 4'b0001 << ref_pick(4'b1010, m_rr));
    end
    req = 4'b0000;
    run_core(2, 16'h3, 16'h4, first);
    tick();
    m_rr = 2;
  endtask

`ifdef CORDIC_ARB_STATS_EN
  task automatic test_stats();
    int c, first, d, m_ops, m_err;
    Reset = 1'b0;
    #4;
    @(posedge Clk); #1;
    Reset = 1'b1;
    m_rr = 0; m_ops = 0; m_err = 0;
    for (int j = 0; j < 4; j++) begin
      req = 4'($urandom_range(1, 15));
      wait_start(c);
      req = 4'b0000;
      d = (j == 2) ? 1000 : $urandom_range(1, 5);
      run_core(d, 16'($urandom), 16'($urandom), first);
      tick();
      if (d > TO) m_err++; else m_ops++;
    end
    n_chk++;
    if (ops_count !== 16'(m_ops) || err_count !== 8'(m_err)) begin
      n_fail++;
      $display("FAIL stats_basic: got ops=%0d err=%0d expected %0d %0d", ops_count, err_count, m_ops, m_err);
    end
    for (int j = 0; j < 256; j++) begin
      req = 4'($urandom_range(1, 15));
      wait_start(c);
      req = 4'b0000;
      run_core(1000, 16'h0, 16'h0, first);
      tick();
      m_err = (m_err < 255) ? m_err + 1 : 255;
    end
    n_chk++;
    if (ops_count !== 16'(m_ops) || err_count !== 8'(m_err)) begin
      n_fail++;
      $display("FAIL stats_sat: got ops=%0d err=%0d expected %0d %0d", ops_count, err_count, m_ops, m_err);
    end
  endtask
`endif

  initial begin
    n_chk = 0; n_fail = 0; m_rr = 0;
    Reset = 1'b0; req = '0; core_done = 1'b0; core_X = '0; core_Y = '0; rsp_ready = 1'b1;
    req_x = '0; req_y = '0; req_a = '0; req_b = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_async_reset();
`ifdef CORDIC_ARB_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_arbiter.md
Name: cordic_arbiter

Overview:
- Shares one CORDIC core (Start / data_out / X / Y interface) between NREQ requesters.
- Arbitrates round-robin and latches the winner's x, y, a, b operands.
- Drives the core's Start and holds its operands stable while it runs.
- Returns X/Y tagged with the requester ID over a valid/ready response port, with a watchdog timeout on a stalled core.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 16, operand/result width.
- TIMEOUT, 63, max WAIT cycles before error (1..255).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- req  input  NREQ  request per requester; level, sampled only in IDLE.
- req_x  input  NREQ*W  packed x operands; requester i at bits [i*W +: W].
- req_y  input  NREQ*W  packed y operands.
- req_a  input  NREQ*W  packed a operands.
- req_b  input  NREQ*W  packed b operands.
- gnt  output  NREQ  one-hot, one-cycle grant pulse.
- core_start  output  1  Start pulse to the CORDIC core.
- core_x, core_y, core_a, core_b  output  W each  registered operands to the core.
- core_done  input  1  core data_out (result valid).
- core_X, core_Y  input  W each  core results.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accepted.
- rsp_id  output  clog2(NREQ)  ID of the serviced requester.
- rsp_X, rsp_Y  output  W each  captured results.
- rsp_err  output  1  response is a timeout; X/Y forced to 0.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (Reset=0, async): state=IDLE, rr_ptr=0, timeout counter=0, all outputs 0.
- Reset mid-operation aborts the job; no response is issued. core_start falls low immediately.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req != 0, pick the first set bit scanning rr_ptr, rr_ptr+1, ... with modulo-NREQ wrap.
  - Latch that requester's operands into core_x/y/a/b and its ID; go to ISSUE.
  - If req == 0, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - gnt[id]=1 and core_start=1 together; clear the timeout counter; go to WAIT.
- WAIT:
  - core_x/y/a/b held constant; counter increments each cycle.
  - On core_done=1: capture core_X/core_Y into rsp_X/rsp_Y, rsp_err=0, go to RESP.
  - Else, when counter==TIMEOUT: rsp_X=rsp_Y=0, rsp_err=1, go to RESP.
  - If core_done and counter==TIMEOUT coincide, core_done wins.
- RESP:
  - rsp_valid=1; rsp_id/X/Y/err stable until accepted.
  - On rsp_valid && rsp_ready: rr_ptr=(id+1) mod NREQ, go to IDLE, rsp_valid falls next cycle.
- core_done outside WAIT is ignored.
- req changes outside IDLE are ignored. A requester dropping req after grant still receives its response.
- Latency:
  - req high at edge t gives gnt/core_start high in cycle t+1.
  - core_done in cycle c gives rsp_valid from cycle c+1.
  - Minimum turnaround after acceptance: 1 IDLE cycle before the next gnt.
- busy=1 in ISSUE, WAIT and RESP.
- Operand selection is a pure W-bit slice; no arithmetic on data.

Optional Feature:
- Macro: CORDIC_ARB_STATS_EN.
- When defined, add output ports ops_count[15:0] and err_count[7:0]:
  - ops_count increments on each accepted response with rsp_err=0.
  - err_count increments on each accepted response with rsp_err=1.
  - Both saturate at all-ones and reset to 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single request: reset, req=4'b0010, req_x[1]=16'h1234; core_done 10 cycles after core_start with core_X=16'h00AA, core_Y=16'h0055 -> gnt=4'b0010 for 1 cycle, core_x=16'h1234, then rsp_valid with rsp_id=1, rsp_X=16'h00AA, rsp_Y=16'h0055, rsp_err=0.
- Round-robin fairness: req=4'b1111 held, rsp_ready=1, core answers after 3 cycles -> grant order 0,1,2,3,0; each gnt is one-hot.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid and data held unchanged; no new gnt; after rsp_ready=1, one IDLE cycle, then next gnt.
- Timeout: TIMEOUT=63, core_done never asserted -> rsp_valid exactly 64 cycles after core_start, rsp_err=1, rsp_X=rsp_Y=0. Variant with core_done in the same cycle the counter reaches 63 -> rsp_err=0.
- Async reset mid-WAIT: drop Reset asynchronously 4 cycles after core_start -> outputs 0 immediately, no response; after release, req=4'b0100 is granted with rr_ptr=0 scan.
- Stats (CORDIC_ARB_STATS_EN defined): 3 good responses and 1 timeout -> ops_count=3, err_count=1; force 256 timeouts -> err_count stays 8'hFF.
